uart_rx_frame_fifo: RTL and testbench

//  Buffers bytes from the UART RX path for the system controller. Captures rx_p_data once per

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_fifo_mem.sv | 26 ++
 rtl/uart_rx_frame_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_frame_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width, error-counter width and the
// pointer-width helper (one extra wrap bit above the address bits).
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_ERR_CNT_W  = 8;

    function automatic int uart_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read, no reset.
// Latency: write visible on the read port the cycle after the write edge; no backpressure.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_fifo.sv
// Captures one UART RX byte per rx_data_valid rising edge into a FWFT FIFO; rd_valid one cycle after push.
// Valid/ready read port; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Optional RX_ERR_CNT_EN adds saturating parity/stop error edge counters.
module uart_rx_frame_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = UART_ERR_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    rx_p_data,
    input  logic                     rx_data_valid,
    input  logic                     rx_par_err,
    input  logic                     rx_stp_err,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fill_level,
`ifdef RX_ERR_CNT_EN
    output logic [CNT_W-1:0]         par_err_cnt,
    output logic [CNT_W-1:0]         stp_err_cnt,
    input  logic                     clr_err_cnt,
`endif
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int PW = uart_ptr_w(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic          r_dv_q;
    logic          r_overflow;
    logic          w_push_req, w_empty, w_full, w_pop, w_push;

    assign w_push_req = rx_data_valid & ~r_dv_q;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                        (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign w_pop      = ~w_empty & rd_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_push     = w_push_req & (~w_full | w_pop);

    // dv_q resets high so a valid level held through reset release is not a new frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dv_q     <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_dv_q <= rx_data_valid;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
            else if (clr_overflow)            r_overflow <= 1'b0;
        end
    end

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr[PW-2:0]),
        .wr_data (rx_p_data),
        .rd_addr (r_rd_ptr[PW-2:0]),
        .rd_data (rd_data)
    );

    assign rd_valid   = ~w_empty;
    assign fifo_full  = w_full;
    assign fill_level = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;

`ifdef RX_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_par_q, r_stp_q;
    logic [CNT_W-1:0] r_par_cnt, r_stp_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_q   <= 1'b1;
            r_stp_q   <= 1'b1;
            r_par_cnt <= '0;
            r_stp_cnt <= '0;
        end else begin
            r_par_q <= rx_par_err;
            r_stp_q <= rx_stp_err;
            if (clr_err_cnt) begin
                r_par_cnt <= '0;
                r_stp_cnt <= '0;
            end else begin
                if (rx_par_err & ~r_par_q & (r_par_cnt != '1)) r_par_cnt <= r_par_cnt + CNT_ONE;
                if (rx_stp_err & ~r_stp_q & (r_stp_cnt != '1)) r_stp_cnt <= r_stp_cnt + CNT_ONE;
            end
        end
    end

    assign par_err_cnt = r_par_cnt;
    assign stp_err_cnt = r_stp_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = rx_par_err ^ rx_stp_err ^ (CNT_W > 0);
`endif

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench for uart_rx_frame_fifo; counter checks build only with RX_ERR_CNT_EN.
module tb_uart_rx_frame_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_p_data = 8'h00;
    logic       rx_data_valid = 1'b1;
    logic       rx_par_err = 1'b0;
    logic       rx_stp_err = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       rd_valid, fifo_full, overflow;
    logic [7:0] rd_data;
    logic [3:0] fill_level;
`ifdef RX_ERR_CNT_EN
    logic [7:0] par_err_cnt, stp_err_cnt;
    logic       clr_err_cnt = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_frame_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .rx_p_data     (rx_p_data),
        .rx_data_valid (rx_data_valid),
        .rx_par_err    (rx_par_err),
        .rx_stp_err    (rx_stp_err),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_full     (fifo_full),
        .fill_level    (fill_level),
`ifdef RX_ERR_CNT_EN
        .par_err_cnt   (par_err_cnt),
        .stp_err_cnt   (stp_err_cnt),
        .clr_err_cnt   (clr_err_cnt),
`endif
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int hold);
        rx_p_data = d;
        rx_data_valid = 1'b1;
        repeat (hold) tick();
        rx_data_valid = 1'b0;
        tick();
    endtask

    task automatic pop_one;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_checks++; if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL rst_fill got %0d want 0", fill_level); end
        n_checks++; if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL rst_full got %b want 0", fifo_full); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL rst_overflow got %b want 0", overflow); end
        #2 reset = 1'b1;
        repeat (5) tick();
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL held_dv_fill got %0d want 0", fill_level); end
        n_checks++; if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL held_dv_rd_valid got %b want 0", rd_valid); end
        rx_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_single;
        rx_p_data = 8'hA5;
        rx_data_valid = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", rd_valid); end
        tick();
        n_checks++; if (rd_valid !== 1'b1)  begin n_fail++; $display("FAIL single_valid got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'hA5)  begin n_fail++; $display("FAIL single_data got %h want a5", rd_data); end
        repeat (15) tick();
        n_checks++; if (fill_level !== 4'd1) begin n_fail++; $display("FAIL single_once got %0d want 1", fill_level); end
        rx_data_valid = 1'b0;
        tick();
        pop_one();
        n_checks++; if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL single_pop_valid got %b want 0", rd_valid); end
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL single_pop_fill got %0d want 0", fill_level); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 8; i++) send_frame(8'(i), 2);
        n_checks++; if (fifo_full !== 1'b1)  begin n_fail++; $display("FAIL ovf_full got %b want 1", fifo_full); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL ovf_pre got %b want 0", overflow); end
        send_frame(8'hFF, 2);
        n_checks++; if (overflow !== 1'b1)   begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        n_checks++; if (fill_level !== 4'd8) begin n_fail++; $display("FAIL ovf_fill got %0d want 8", fill_level); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                n_fail++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'(i));
            end
            pop_one();
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", rd_valid); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h10 + 8'(i), 2);
            q.push_back(8'h10 + 8'(i));
        end
        for (int k = 0; k < 24; k++) begin
            exp = q.pop_front();
            n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL fpp_head[%0d] got %h want %h", k, rd_data, exp); end
            rx_p_data = 8'h20 + 8'(k);
            rx_data_valid = 1'b1;
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            rx_data_valid = 1'b0;
            q.push_back(8'h20 + 8'(k));
            tick();
            n_checks++; if (fill_level !== 4'd8) begin n_fail++; $display("FAIL fpp_fill[%0d] got %0d want 8", k, fill_level); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got %b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            exp = q.pop_front();
            n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL fpp_drain[%0d] got %h want %h", i, rd_data, exp); end
            pop_one();
        end
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL fpp_end got %0d want 0", fill_level); end
    endtask

    task automatic test_clr_priority;
        for (int i = 0; i < 8; i++) send_frame(8'h30 + 8'(i), 2);
        rx_p_data = 8'hFF;
        rx_data_valid = 1'b1;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        rx_data_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_prio got %b want 1", overflow); end
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %b want 0", overflow); end
        n_checks++; if (rd_data !== 8'h30) begin n_fail++; $display("FAIL clr_head got %h want 30", rd_data); end
        rd_ready = 1'b1;
        repeat (8) tick();
        rd_ready = 1'b0;
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL clr_drain got %0d want 0", fill_level); end
    endtask

    task automatic test_empty_push_pop;
        rd_ready = 1'b1;
        rx_p_data = 8'h5C;
        rx_data_valid = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_checks++; if (fill_level !== 4'd1) begin n_fail++; $display("FAIL epp_fill got %0d want 1", fill_level); end
        n_checks++; if (rd_data !== 8'h5C)   begin n_fail++; $display("FAIL epp_data got %h want 5c", rd_data); end
        rx_data_valid = 1'b0;
        tick();
        pop_one();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL epp_pop got %b want 0", rd_valid); end
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 0; i < 9; i++) send_frame(8'h40 + 8'(i), 2);
        pop_one();
        pop_one();
        n_checks++; if (fill_level !== 4'd6) begin n_fail++; $display("FAIL rmd_pre got %0d want 6", fill_level); end
        rd_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL rmd_valid got %b want 0", rd_valid); end
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL rmd_fill got %0d want 0", fill_level); end
        n_checks++; if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL rmd_full got %b want 0", fifo_full); end
        n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL rmd_overflow got %b want 0", overflow); end
        rd_ready = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();
        n_checks++; if (fill_level !== 4'd0) begin n_fail++; $display("FAIL rmd_after got %0d want 0", fill_level); end
    endtask

`ifdef RX_ERR_CNT_EN
    task automatic test_err_counters;
        n_checks++; if (par_err_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_par_rst got %0d want 0", par_err_cnt); end
        for (int i = 0; i < 300; i++) begin
            rx_par_err = 1'b1; tick();
            rx_par_err = 1'b0; tick();
        end
        n_checks++; if (par_err_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_par_sat got %0d want 255", par_err_cnt); end
        for (int i = 0; i < 3; i++) begin
            rx_stp_err = 1'b1; tick();
            rx_stp_err = 1'b0; tick();
        end
        n_checks++; if (stp_err_cnt !== 8'd3) begin n_fail++; $display("FAIL cnt_stp got %0d want 3", stp_err_cnt); end
        rx_stp_err = 1'b1;
        clr_err_cnt = 1'b1;
        tick();
        clr_err_cnt = 1'b0;
        tick();
        rx_stp_err = 1'b0;
        tick();
        n_checks++; if (stp_err_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_clr_stp got %0d want 0", stp_err_cnt); end
        n_checks++; if (par_err_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_clr_par got %0d want 0", par_err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clr_priority();
        test_empty_push_pop();
        test_reset_mid_drain();
`ifdef RX_ERR_CNT_EN
        test_err_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
